// File: rtl/minibyte_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : minibyte_pkg
//  Brief    : Shared encodings for the MiniByte control unit: FSM state codes,
//             opcode map, ACC source select and ALU operation codes.
//  Revision : 1.0 - initial release
// ============================================================================
package minibyte_pkg;

   // FSM state encodings (also exported on state_dbg)
   localparam logic [3:0] ST_RESET  = 4'd0;
   localparam logic [3:0] ST_FETCH  = 4'd1;
   localparam logic [3:0] ST_DECODE = 4'd2;
   localparam logic [3:0] ST_ARG    = 4'd3;
   localparam logic [3:0] ST_EXEC   = 4'd4;
   localparam logic [3:0] ST_MEM    = 4'd5;
   localparam logic [3:0] ST_HALT   = 4'd6;
   localparam logic [3:0] ST_STEP   = 4'd7;

   // Opcode map (IR[7:4]); B..E are illegal and behave as NOP
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_RSV = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   // ACC load source select
   localparam logic [1:0] ACC_SRC_ALU = 2'd0;
   localparam logic [1:0] ACC_SRC_BUS = 2'd1;
   localparam logic [1:0] ACC_SRC_ARG = 2'd2;

   // ALU operation codes
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_OR  = 2'd3;

endpackage : minibyte_pkg
`default_nettype wire

// File: rtl/minibyte_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : minibyte_op_decode
//  Brief    : Combinational opcode classifier for the MiniByte control FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module minibyte_op_decode
   import minibyte_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       needs_arg,
   output logic       is_mem,
   output logic       is_store,
   output logic       is_jump,
   output logic       is_halt,
   output logic [1:0] alu_op
);

   // Classify the opcode into the attributes the sequencer needs
   always_comb begin
      needs_arg = (opcode >= OP_LDI) && (opcode <= OP_RSV);
      is_mem    = (opcode >= OP_LDA) && (opcode <= OP_OR);
      is_store  = (opcode == OP_STA);
      is_jump   = (opcode == OP_JMP) || (opcode == OP_JZ);
      is_halt   = (opcode == OP_HLT);
      // For ADD..OR (4..7), op-4 is exactly the low two opcode bits
      alu_op    = ALU_ADD;
      if ((opcode >= OP_ADD) && (opcode <= OP_OR)) begin
         alu_op = opcode[1:0];
      end
   end

endmodule : minibyte_op_decode
`default_nettype wire

// File: rtl/minibyte_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : minibyte_ctrl_fsm
//  Brief    : Fetch/decode/execute sequencer for the MiniByte 8-bit
//             accumulator CPU. Owns the memory bus handshake and drives the
//             PC/IR/ARG/ACC datapath strobes.
//  Options  : MINIBYTE_SINGLE_STEP_EN - adds the step input and the STEP
//             state entered after every completed instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module minibyte_ctrl_fsm
   import minibyte_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
`ifdef MINIBYTE_SINGLE_STEP_EN
   input  logic       step,
`endif
   input  logic [3:0] ir_opcode,
   input  logic       acc_zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_load,
   output logic       arg_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       acc_load,
   output logic [1:0] acc_src,
   output logic [1:0] alu_op,
   output logic       halted,
   output logic [3:0] state_dbg
);

   // Where the sequencer goes once an instruction has completed
`ifdef MINIBYTE_SINGLE_STEP_EN
   localparam logic [3:0] ST_NEXT_INSN = ST_STEP;
`else
   localparam logic [3:0] ST_NEXT_INSN = ST_FETCH;
`endif

   logic [3:0] state_q;
   logic [3:0] state_d;

   logic       dec_needs_arg;
   logic       dec_is_mem;
   logic       dec_is_store;
   logic       dec_is_jump;
   logic       dec_is_halt;
   logic [1:0] dec_alu_op;

   minibyte_op_decode u_op_decode (
      .opcode    (ir_opcode),
      .needs_arg (dec_needs_arg),
      .is_mem    (dec_is_mem),
      .is_store  (dec_is_store),
      .is_jump   (dec_is_jump),
      .is_halt   (dec_is_halt),
      .alu_op    (dec_alu_op)
   );

   // State register; reset forces RESET, where every output is inactive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and strobes; with ena low the state holds and strobes drop
   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_load  = 1'b0;
      arg_load = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      acc_load = 1'b0;
      acc_src  = ACC_SRC_ALU;
      alu_op   = ALU_ADD;

      if (ena) begin
         case (state_q)
            ST_RESET: begin
               state_d = ST_NEXT_INSN;
            end

            ST_FETCH: begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  ir_load = 1'b1;
                  pc_inc  = 1'b1;
                  state_d = ST_DECODE;
               end
            end

            ST_DECODE: begin
               if (dec_is_halt) begin
                  state_d = ST_HALT;
               end else if (dec_needs_arg) begin
                  state_d = ST_ARG;
               end else begin
                  // NOP and the illegal opcodes finish here
                  state_d = ST_NEXT_INSN;
               end
            end

            ST_ARG: begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  arg_load = 1'b1;
                  pc_inc   = 1'b1;
                  state_d  = ST_EXEC;
               end
            end

            ST_EXEC: begin
               if (ir_opcode == OP_LDI) begin
                  acc_load = 1'b1;
                  acc_src  = ACC_SRC_ARG;
               end
               if (dec_is_jump) begin
                  pc_load = (ir_opcode == OP_JMP) || acc_zero;
               end
               state_d = dec_is_mem ? ST_MEM : ST_NEXT_INSN;
            end

            ST_MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = dec_is_store;
               if (mem_ack) begin
                  if (!dec_is_store) begin
                     acc_load = 1'b1;
                     if (ir_opcode == OP_LDA) begin
                        acc_src = ACC_SRC_BUS;
                     end else begin
                        acc_src = ACC_SRC_ALU;
                        alu_op  = dec_alu_op;
                     end
                  end
                  state_d = ST_NEXT_INSN;
               end
            end

            ST_HALT: begin
               state_d = ST_HALT;
            end

`ifdef MINIBYTE_SINGLE_STEP_EN
            ST_STEP: begin
               if (step) begin
                  state_d = ST_FETCH;
               end
            end
`endif

            default: begin
               state_d = ST_RESET;
            end
         endcase
      end
   end

   assign halted    = (state_q == ST_HALT);
   assign state_dbg = state_q;

endmodule : minibyte_ctrl_fsm
`default_nettype wire

// File: tb/tb_minibyte_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_minibyte_ctrl_fsm
//  Brief    : Self-checking bench for minibyte_ctrl_fsm. Instructions are
//             expanded into per-cycle expected bus/strobe traces from the
//             instruction timing rules, then replayed against the DUT.
//  Options  : MINIBYTE_SINGLE_STEP_EN - exercises the STEP state as well.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_minibyte_ctrl_fsm;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       ir_load;
      logic       arg_load;
      logic       pc_inc;
      logic       pc_load;
      logic       acc_load;
      logic [1:0] acc_src;
      logic [1:0] alu_op;
      logic       halted;
      logic [3:0] state_dbg;
   } outs_t;

   typedef struct {
      logic       ena;
      logic       ack;
      logic       step;
      logic       az;
      logic [3:0] op;
      outs_t      exp;
      int         insn;
   } cyc_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       step;
   logic [3:0] ir_opcode;
   logic       acc_zero;
   logic       mem_ack;
   outs_t      dut;

   cyc_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   insn_id = 0;
   int   cyc_no = 0;

   always #5 clk = ~clk;

   minibyte_ctrl_fsm u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
`ifdef MINIBYTE_SINGLE_STEP_EN
      .step      (step),
`endif
      .ir_opcode (ir_opcode),
      .acc_zero  (acc_zero),
      .mem_ack   (mem_ack),
      .mem_req   (dut.mem_req),
      .mem_we    (dut.mem_we),
      .addr_sel  (dut.addr_sel),
      .ir_load   (dut.ir_load),
      .arg_load  (dut.arg_load),
      .pc_inc    (dut.pc_inc),
      .pc_load   (dut.pc_load),
      .acc_load  (dut.acc_load),
      .acc_src   (dut.acc_src),
      .alu_op    (dut.alu_op),
      .halted    (dut.halted),
      .state_dbg (dut.state_dbg)
   );

   // ---------------------------------------------------------------- model
   task automatic push(input logic en, input logic ack, input logic st,
                       input logic az, input logic [3:0] op, input outs_t e);
      cyc_t c;
      c.ena = en; c.ack = ack; c.step = st; c.az = az; c.op = op;
      c.exp = e; c.insn = insn_id;
      q.push_back(c);
   endtask

   function automatic outs_t idle(input logic [3:0] st);
      outs_t o;
      o = '0;
      o.state_dbg = st;
      o.halted    = (st == 4'd6);
      return o;
   endfunction

   // Single-step pause: two idle cycles, then the step pulse
   task automatic add_step();
`ifdef MINIBYTE_SINGLE_STEP_EN
      push(1, 1, 0, 0, 4'h0, idle(4'd7));
      push(1, 0, 0, 0, 4'h0, idle(4'd7));
      push(1, 0, 1, 0, 4'h0, idle(4'd7));
`endif
   endtask

   task automatic add_fetch_waits(input int n, input logic [3:0] op);
      outs_t o;
      for (int i = 0; i < n; i++) begin
         o = idle(4'd1); o.mem_req = 1;
         push(1, 0, 0, 0, op, o);
      end
   endtask

   // One instruction: wf/wa/wm wait cycles on the opcode, operand and data
   // accesses; stray drives ack in cycles with no request; pause_arg
   // inserts a 3-cycle ena=0 window inside the operand access.
   task automatic add_insn(input logic [3:0] op, input int wf, input int wa,
                           input int wm, input logic az, input logic stray,
                           input logic pause_arg);
      outs_t o;
      insn_id++;
      add_fetch_waits(wf, op);
      o = idle(4'd1); o.mem_req = 1; o.ir_load = 1; o.pc_inc = 1;
      push(1, 1, 0, az, op, o);
      push(1, stray, 0, az, op, idle(4'd2));
      if (op == 4'hF) return;
      if (op == 4'h0 || (op >= 4'hB && op <= 4'hE)) return;
      if (pause_arg) begin
         o = idle(4'd3); o.mem_req = 1;
         push(1, 0, 0, az, op, o);
         for (int i = 0; i < 3; i++) push(0, 1, 0, az, op, idle(4'd3));
      end
      for (int i = 0; i < wa; i++) begin
         o = idle(4'd3); o.mem_req = 1;
         push(1, 0, 0, az, op, o);
      end
      o = idle(4'd3); o.mem_req = 1; o.arg_load = 1; o.pc_inc = 1;
      push(1, 1, 0, az, op, o);
      o = idle(4'd4);
      if (op == 4'h1) begin o.acc_load = 1; o.acc_src = 2'd2; end
      if (op == 4'h8) o.pc_load = 1;
      if (op == 4'h9) o.pc_load = az;
      push(1, stray, 0, az, op, o);
      if (op >= 4'h2 && op <= 4'h7) begin
         for (int i = 0; i < wm; i++) begin
            o = idle(4'd5); o.mem_req = 1; o.addr_sel = 1; o.mem_we = (op == 4'h3);
            push(1, 0, 0, az, op, o);
         end
         o = idle(4'd5); o.mem_req = 1; o.addr_sel = 1; o.mem_we = (op == 4'h3);
         if (op != 4'h3) begin
            o.acc_load = 1;
            if (op == 4'h2) o.acc_src = 2'd1;
            else            o.alu_op  = 2'(op - 4'h4);
         end
         push(1, 1, 0, az, op, o);
      end
   endtask

   task automatic add_halt(input int n);
      for (int i = 0; i < n; i++) push(1, i[0], 0, 0, 4'hF, idle(4'd6));
      push(0, 1, 0, 0, 4'hF, idle(4'd6));
      push(0, 0, 0, 0, 4'hF, idle(4'd6));
   endtask

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic check_outs(input string name, input outs_t want);
      total++;
      if (dut !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc_no, dut, want);
      end
   endtask

   // Replay the queue: drive just after the rising edge, compare on falling
   task automatic run_queue();
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         ena = c.ena; mem_ack = c.ack; step = c.step;
         acc_zero = c.az; ir_opcode = c.op;
         @(negedge clk);
         total++;
         if (dut !== c.exp) begin
            bad++;
            $display("FAIL trace insn=%0d op=%h cyc=%0d got=%h want=%h",
                     c.insn, c.op, cyc_no, dut, c.exp);
         end
         cyc_no++;
         @(posedge clk);
         #1;
      end
      ena = 1; mem_ack = 0; step = 0;
   endtask

   task automatic hold_reset(input int n);
      outs_t z;
      z = '0;
      #1 rst_n = 0;
      for (int i = 0; i < n; i++) begin
         ena     = i[0];
         mem_ack = ~i[0];
         @(negedge clk);
         check_outs("reset_zero", z);
         cyc_no++;
      end
      rst_n = 1;
      ena = 1; mem_ack = 0;
      @(posedge clk);
      #1;
   endtask

   int   n0;
   int   nreq;

   initial begin
      rst_n = 0; ena = 0; step = 0; ir_opcode = 4'h0; acc_zero = 0; mem_ack = 0;

      // Model pins: instruction lengths with zero-wait ack and the ADD wait run
      n0 = q.size(); add_insn(4'h0, 0, 0, 0, 0, 0, 0); check("len_nop", q.size() - n0, 2);
      n0 = q.size(); add_insn(4'h1, 0, 0, 0, 0, 0, 0); check("len_ldi", q.size() - n0, 4);
      n0 = q.size(); add_insn(4'h4, 0, 0, 0, 0, 0, 0); check("len_add", q.size() - n0, 5);
      n0 = q.size(); add_insn(4'h4, 0, 0, 3, 0, 0, 0); check("len_add_w3", q.size() - n0, 8);
      nreq = 0;
      for (int i = n0; i < q.size(); i++)
         if (q[i].exp.mem_req && q[i].exp.addr_sel) nreq++;
      check("add_w3_mem_cycles", nreq, 4);
      check("add_w3_alu", int'(q[q.size()-1].exp.alu_op), 0);
      q.delete();
      insn_id = 0;

      @(posedge clk);
      hold_reset(4);

      // Main program
      add_step();
      add_insn(4'h0, 0, 0, 0, 0, 1, 0); add_step();   // NOP, stray ack in DECODE
      add_insn(4'h1, 0, 0, 0, 0, 0, 0); add_step();   // LDI zero wait
      add_insn(4'h4, 0, 0, 3, 0, 1, 0); add_step();   // ADD, 3 data waits
      add_insn(4'h3, 1, 0, 1, 0, 0, 0); add_step();   // STA
      add_insn(4'h2, 0, 2, 0, 1, 0, 0); add_step();   // LDA
      add_insn(4'h5, 0, 0, 0, 0, 0, 0); add_step();   // SUB
      add_insn(4'h6, 0, 0, 1, 0, 0, 0); add_step();   // AND
      add_insn(4'h7, 2, 0, 0, 0, 0, 0); add_step();   // OR
      add_insn(4'h9, 0, 0, 0, 0, 1, 0); add_step();   // JZ not taken
      add_insn(4'h9, 0, 0, 0, 1, 0, 0); add_step();   // JZ taken
      add_insn(4'h8, 0, 1, 0, 0, 0, 0); add_step();   // JMP
      add_insn(4'hC, 0, 0, 0, 0, 1, 0); add_step();   // illegal -> NOP
      add_insn(4'hA, 0, 0, 0, 0, 0, 0); add_step();   // reserved -> NOP after ARG
      add_insn(4'h1, 0, 1, 0, 0, 0, 1); add_step();   // LDI with ena pause mid-ARG
      add_insn(4'hF, 0, 0, 0, 0, 1, 0);               // HLT
      add_halt(20);
      run_queue();

      // Leave HALT through reset, then abandon a fetch mid-transfer
      hold_reset(2);
      add_step();
      add_fetch_waits(2, 4'h1);
      run_queue();
      hold_reset(2);
      add_step();
      add_insn(4'h1, 1, 0, 0, 0, 0, 0); add_step();
      add_insn(4'h4, 0, 0, 0, 0, 0, 0);
      run_queue();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule : tb_minibyte_ctrl_fsm
`default_nettype wire
